// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// controller state encoding and the funct7 value that selects the M extension.
package muldiv_pkg;

    // M-extension operation select (funct3)
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // funct7 that marks an OP instruction as M-extension (used by decode)
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FINAL = 2'b10,
        ST_DONE  = 2'b11
    } md_state_e;

    // All divide/remainder encodings have funct3[2] set
    function automatic logic md_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage control and the
// multiply/divide sequencer.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider datapath. Operands are
// reduced to magnitudes at load; signs are re-applied in the finalize cycle.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_finalize,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_dz,
    input  logic            i_ovf,
    output logic [XLEN-1:0] o_result
);

    // Multiply: r_hi = partial product high half, r_lo = multiplier shifting out.
    // Divide:   r_hi = partial remainder, r_lo = dividend shifting out / quotient in.
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opb;
    logic [2:0]      r_funct3;
    logic            r_neg_prod;
    logic            r_neg_quo;
    logic            r_neg_rem;
    logic            r_dz;
    logic            r_ovf;
    logic [XLEN-1:0] r_result;

    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_trial;
    logic            w_ge;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_final;

    assign w_a_signed = (i_funct3 == MD_MUL) || (i_funct3 == MD_MULH) ||
                        (i_funct3 == MD_MULHSU) || (i_funct3 == MD_DIV) ||
                        (i_funct3 == MD_REM);
    assign w_b_signed = (i_funct3 == MD_MUL) || (i_funct3 == MD_MULH) ||
                        (i_funct3 == MD_DIV) || (i_funct3 == MD_REM);
    assign w_sa    = w_a_signed & i_rs1[XLEN-1];
    assign w_sb    = w_b_signed & i_rs2[XLEN-1];
    assign w_abs_a = w_sa ? ('0 - i_rs1) : i_rs1;
    assign w_abs_b = w_sb ? ('0 - i_rs2) : i_rs2;

    // Multiply step: conditional add, then shift the carry back into the pair
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);

    // Divide step: shift one dividend bit into the remainder, trial-subtract
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    assign w_trial = w_shift[XLEN-1:0] - r_opb;

    assign w_prod_fix = r_neg_prod ? ('0 - {r_hi, r_lo}) : {r_hi, r_lo};
    assign w_quo_fix  = r_neg_quo  ? ('0 - r_lo) : r_lo;
    assign w_rem_fix  = r_neg_rem  ? ('0 - r_hi) : r_hi;

    // Select the architectural result and apply the divide special cases
    always_comb begin
        w_final = '0;
        case (r_funct3)
            MD_MUL:                       w_final = w_prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU: begin
                if (r_dz)
                    w_final = '1;
                else if (r_ovf)
                    w_final = {1'b1, {(XLEN-1){1'b0}}};
                else
                    w_final = w_quo_fix;
            end
            default: begin
                if (r_ovf)
                    w_final = '0;
                else
                    w_final = w_rem_fix;
            end
        endcase
    end

    // Operand load, per-cycle iteration and result capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_funct3   <= MD_MUL;
            r_neg_prod <= 1'b0;
            r_neg_quo  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
        end else if (i_load) begin
            r_funct3   <= i_funct3;
            r_neg_prod <= w_sa ^ w_sb;
            r_neg_quo  <= w_sa ^ w_sb;
            r_neg_rem  <= w_sa;
            r_dz       <= i_dz;
            r_ovf      <= i_ovf;
            if (md_is_div(i_funct3)) begin
                // On divide-by-zero the remainder is the dividend itself;
                // preloading it lets the normal sign fixup produce rs1.
                r_hi  <= i_dz ? w_abs_a : '0;
                r_lo  <= w_abs_a;
                r_opb <= w_abs_b;
            end else begin
                r_hi  <= '0;
                r_lo  <= w_abs_b;
                r_opb <= w_abs_a;
            end
        end else if (i_step) begin
            if (md_is_div(r_funct3)) begin
                r_hi <= w_ge ? w_trial : w_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_ge};
            end else begin
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
        end else if (i_finalize) begin
            r_result <= w_final;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: accepts a request in IDLE, runs XLEN
// iterations (or skips them for the divide special cases), finalizes,
// pulses done, and holds busy for the whole operation.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic   clk,
    input  logic   reset_n,
    muldiv_if.slave bus
);

    md_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;

    logic            w_dz;
    logic            w_ovf;
    logic            w_load;
    logic            w_step;
    logic            w_finalize;
    logic [XLEN-1:0] w_result;

    // Divide special cases bypass the iteration loop
    assign w_dz  = md_is_div(bus.funct3) && (bus.rs2 == '0);
    assign w_ovf = ((bus.funct3 == MD_DIV) || (bus.funct3 == MD_REM)) &&
                   (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);

    // flush suppresses every datapath update, so a killed op leaves result intact
    assign w_load     = (r_state == ST_IDLE)  && bus.start && !bus.flush;
    assign w_step     = (r_state == ST_CALC)  && !bus.flush;
    assign w_finalize = (r_state == ST_FINAL) && !bus.flush;

    // Control FSM with registered busy/done
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (w_dz || w_ovf) ? ST_FINAL : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1))
                        r_state <= ST_FINAL;
                end
                ST_FINAL: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_finalize (w_finalize),
        .i_funct3   (bus.funct3),
        .i_rs1      (bus.rs1),
        .i_rs2      (bus.rs2),
        .i_dz       (w_dz),
        .i_ovf      (w_ovf),
        .o_result   (w_result)
    );

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = w_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: each RV32M op, divide special cases,
// flush, start-while-busy and mid-operation reset.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk;
    logic reset_n;
    int   n_total;
    int   n_pass;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one op and wait for done. If inj_k > 0, a conflicting start is
    // driven at sample inj_k; it must be ignored while busy.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int inj_k,
                         input string tag);
        int  k;
        bit  busy_ok;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && k < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (k == inj_k) begin
                bus.start  = 1'b1;
                bus.funct3 = MD_DIVU;
                bus.rs1    = 32'h0000_1234;
                bus.rs2    = 32'h0;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            k++;
        end
        chk({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_result"}, bus.result, exp_res);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_result_hold"}, bus.result, exp_res);
        $display("op %s f3=%0d rs1=%h rs2=%h -> result=%h latency=%0d",
                 tag, f3, a, b, bus.result, k);
    endtask

    initial begin
        bit done_seen;
        n_total    = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1    = '0;
        bus.rs2    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, "mul");
        do_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, "mulh");
        do_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, "mulhu");
        do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0, "mulhsu");
        do_op(MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 0, "div");
        do_op(MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0, "rem");
        do_op(MD_DIVU,   32'd100,       32'd7,         32'd14,        34, 0, "divu");
        do_op(MD_REMU,   32'd100,       32'd7,         32'd2,         34, 0, "remu");
        do_op(MD_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 2,  0, "divu_by0");
        do_op(MD_REM,    32'd5,         32'd0,         32'd5,         2,  0, "rem_by0");
        do_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  0, "div_ovf");

        // Flush mid-CALC: busy drops, no done, result keeps 0x80000000
        bus.funct3 = MD_MUL;
        bus.rs1    = 32'd7;
        bus.rs2    = 32'hFFFF_FFFD;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_done", {31'd0, bus.done}, 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        chk("flush_no_done", {31'd0, done_seen}, 32'd0);
        chk("flush_result_kept", bus.result, 32'h8000_0000);
        $display("op flush_mul result=%h", bus.result);

        do_op(MD_DIVU,   32'd9,         32'd3,         32'd3,         34, 0, "divu_after_flush");
        do_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  0, "rem_ovf");
        do_op(MD_DIVU,   32'd100,       32'd7,         32'd14,        34, 5, "start_while_busy");

        // Reset mid-CALC: everything clears, no done afterwards
        bus.funct3 = MD_MUL;
        bus.rs1    = 32'd7;
        bus.rs2    = 32'hFFFF_FFFD;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_done", {31'd0, bus.done}, 32'd0);
        chk("midreset_result", bus.result, 32'd0);
        done_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        chk("midreset_no_done", {31'd0, done_seen}, 32'd0);
        $display("op midreset_mul result=%h", bus.result);

        do_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, "mulhu_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
